// File: rtl/uart_rx_pkg.sv
// Shared constants for the UART receive front end: FSM state codes and the
// mid-bit sample offsets measured from H = Prescale>>1.
package uart_rx_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  // s0 is taken one edge before H, s1 at H, the vote at H+1, the decision at H+2
  localparam int unsigned SMP_S0_BACK  = 1;
  localparam int unsigned SMP_S1_FWD   = 0;
  localparam int unsigned SMP_VOTE_FWD = 1;
  localparam int unsigned SMP_CHK_FWD  = 2;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Captures two mid-bit samples of the serial line and forms the
// 3-sample majority with the live line value.
module uart_rx_sampler
  import uart_rx_pkg::*;
#(
  parameter int PS_W = 6
) (
  input  logic            Clk,
  input  logic            Rst,
  input  logic [PS_W-1:0] i_edge_cnt,
  input  logic [PS_W-1:0] i_h,
  input  logic            i_rx,
  output logic            o_maj
);

  logic r_s0;
  logic r_s1;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_s0 <= 1'b0;
      r_s1 <= 1'b0;
    end else begin
      if (i_edge_cnt == i_h - PS_W'(SMP_S0_BACK)) r_s0 <= i_rx;
      if (i_edge_cnt == i_h + PS_W'(SMP_S1_FWD))  r_s1 <= i_rx;
    end
  end

  assign o_maj = maj3(r_s0, r_s1, i_rx);

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// UART receive frame controller: start detection, oversampled bit recovery,
// LSB-first deserialisation and parity/stop sequencing.
module uart_rx_frame_ctrl
  import uart_rx_pkg::*;
#(
  parameter int Width = 8,
  parameter int PS_W  = 6
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             RX_IN,
  input  logic [PS_W-1:0]  Prescale,
  input  logic             PAR_EN,
  input  logic             Parity_err,
  output logic             Sampled_bit,
  output logic [Width-1:0] P_Data,
  output logic             Parity_en,
  output logic             Data_valid,
  output logic             Stop_err
);

  localparam int BC_W = (Width > 1) ? $clog2(Width) : 1;

  logic [2:0]       r_state;
  logic [PS_W-1:0]  r_edge_cnt;
  logic [BC_W-1:0]  r_bit_cnt;
  logic [PS_W-1:0]  r_ps;
  logic             r_par_en;
  logic             r_par_bad;
  logic             r_sampled_bit;
  logic [Width-1:0] r_p_data;
  logic             r_data_valid;
  logic             r_stop_err;

  logic [PS_W-1:0]  w_h;
  logic             w_last;
  logic             w_vote_pt;
  logic             w_chk_pt;
  logic             w_maj;

  assign w_h       = r_ps >> 1;
  assign w_last    = (r_edge_cnt == r_ps - 1'b1);
  assign w_vote_pt = (r_edge_cnt == w_h + PS_W'(SMP_VOTE_FWD));
  assign w_chk_pt  = (r_edge_cnt == w_h + PS_W'(SMP_CHK_FWD));

  uart_rx_sampler #(
    .PS_W (PS_W)
  ) u_sampler (
    .Clk        (Clk),
    .Rst        (Rst),
    .i_edge_cnt (r_edge_cnt),
    .i_h        (w_h),
    .i_rx       (RX_IN),
    .o_maj      (w_maj)
  );

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_state       <= ST_IDLE;
      r_edge_cnt    <= '0;
      r_bit_cnt     <= '0;
      r_ps          <= '0;
      r_par_en      <= 1'b0;
      r_par_bad     <= 1'b0;
      r_sampled_bit <= 1'b0;
      r_p_data      <= '0;
      r_data_valid  <= 1'b0;
      r_stop_err    <= 1'b0;
    end else begin
      r_data_valid <= 1'b0;
      r_stop_err   <= 1'b0;

      if (r_state != ST_IDLE) begin
        r_edge_cnt <= w_last ? '0 : r_edge_cnt + 1'b1;
        if (w_vote_pt) r_sampled_bit <= w_maj;
      end

      case (r_state)
        ST_IDLE: begin
          // Frame configuration is frozen here for the whole frame
          if (!RX_IN) begin
            r_state    <= ST_START;
            r_edge_cnt <= '0;
            r_ps       <= Prescale;
            r_par_en   <= PAR_EN;
            r_par_bad  <= 1'b0;
          end
        end
        ST_START: begin
          if (w_chk_pt && r_sampled_bit) begin
            r_state    <= ST_IDLE;
            r_edge_cnt <= '0;
          end else if (w_last) begin
            r_state   <= ST_DATA;
            r_bit_cnt <= '0;
          end
        end
        ST_DATA: begin
          if (w_vote_pt) r_p_data <= {w_maj, r_p_data[Width-1:1]};
          if (w_last) begin
            if (r_bit_cnt == BC_W'(Width - 1)) r_state <= r_par_en ? ST_PARITY : ST_STOP;
            else                               r_bit_cnt <= r_bit_cnt + 1'b1;
          end
        end
        ST_PARITY: begin
          if (w_last) begin
            r_state <= ST_STOP;
            if (Parity_err) r_par_bad <= 1'b1;
          end
        end
        ST_STOP: begin
          // Stop error takes precedence, so the two pulses are exclusive
          if (w_last) begin
            r_state <= ST_IDLE;
            if (!r_sampled_bit)  r_stop_err   <= 1'b1;
            else if (!r_par_bad) r_data_valid <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign Parity_en   = (r_state == ST_PARITY) && w_chk_pt;
  assign Sampled_bit = r_sampled_bit;
  assign P_Data      = r_p_data;
  assign Data_valid  = r_data_valid;
  assign Stop_err    = r_stop_err;

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Directed bench for uart_rx_frame_ctrl with a small even-parity checker
// model closing the Parity_en / Parity_err loop.
module tb_uart_rx_frame_ctrl;

  localparam int   Width   = 8;
  localparam int   PS_W    = 6;
  localparam logic PAR_TYP = 1'b0;

  logic             Clk      = 1'b0;
  logic             Rst      = 1'b0;
  logic             RX_IN    = 1'b1;
  logic [PS_W-1:0]  Prescale = 6'd8;
  logic             PAR_EN   = 1'b0;
  logic             Parity_err;
  logic             Sampled_bit;
  logic [Width-1:0] P_Data;
  logic             Parity_en;
  logic             Data_valid;
  logic             Stop_err;

  int n_cmp = 0;
  int n_err = 0;

  int         n_dv   = 0;
  int         n_se   = 0;
  int         n_pe   = 0;
  int         n_both = 0;
  logic [7:0] dv_data [0:15];
  logic       last_perr = 1'b0;
  logic       pe_d      = 1'b0;

  always #5 Clk = ~Clk;

  uart_rx_frame_ctrl #(
    .Width (Width),
    .PS_W  (PS_W)
  ) dut (
    .Clk         (Clk),
    .Rst         (Rst),
    .RX_IN       (RX_IN),
    .Prescale    (Prescale),
    .PAR_EN      (PAR_EN),
    .Parity_err  (Parity_err),
    .Sampled_bit (Sampled_bit),
    .P_Data      (P_Data),
    .Parity_en   (Parity_en),
    .Data_valid  (Data_valid),
    .Stop_err    (Stop_err)
  );

  // Parity checker neighbour: registered error, held until the next strobe
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst)           Parity_err <= 1'b0;
    else if (Parity_en) Parity_err <= (^{P_Data, Sampled_bit}) ^ PAR_TYP;
  end

  always @(negedge Clk) begin
    if (Data_valid) begin
      if (n_dv < 16) dv_data[n_dv] = P_Data;
      n_dv = n_dv + 1;
    end
    if (Stop_err) n_se = n_se + 1;
    if (Data_valid && Stop_err) n_both = n_both + 1;
    if (Parity_en) n_pe = n_pe + 1;
    if (pe_d) last_perr = Parity_err;
    pe_d = Parity_en;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (got !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  // Drives one frame, one line value per clock; optional single-clock glitch
  // at clock index glitch_j and optional mid-frame Prescale/PAR_EN change.
  task automatic send_frame(input logic [7:0] d, input int ps, input logic pen,
                            input logic pbit, input logic sbit, input int glitch_j,
                            input int ps_mid);
    logic bits [0:10];
    int   nb;
    Prescale = PS_W'(ps);
    PAR_EN   = pen;
    bits[0]  = 1'b0;
    for (int i = 0; i < 8; i++) bits[i+1] = d[i];
    nb = 9;
    if (pen) begin
      bits[nb] = pbit;
      nb = nb + 1;
    end
    bits[nb] = sbit;
    nb = nb + 1;
    for (int j = 0; j < nb * ps; j++) begin
      RX_IN = bits[j / ps] ^ (j == glitch_j);
      if (j == ps && ps_mid != ps) begin
        Prescale = PS_W'(ps_mid);
        PAR_EN   = ~pen;
      end
      @(posedge Clk);
      #1;
    end
    RX_IN = 1'b1;
  endtask

  int s_dv, s_se, s_pe;

  task automatic snap();
    s_dv = n_dv;
    s_se = n_se;
    s_pe = n_pe;
  endtask

  initial begin
    Rst   = 1'b0;
    RX_IN = 1'b1;
    idle(3);
    chk("rst_sampled_bit", 32'(Sampled_bit), 32'h0);
    chk("rst_p_data",      32'(P_Data),      32'h0);
    chk("rst_parity_en",   32'(Parity_en),   32'h0);
    chk("rst_data_valid",  32'(Data_valid),  32'h0);
    chk("rst_stop_err",    32'(Stop_err),    32'h0);
    Rst = 1'b1;
    idle(4);

    // 1: Prescale 8, even parity, 0xA5 with parity bit 0
    snap();
    send_frame(8'hA5, 8, 1'b1, 1'b0, 1'b1, -1, 8);
    idle(16);
    chk("t1_dv_count", 32'(n_dv - s_dv), 32'd1);
    chk("t1_p_data",   32'(dv_data[s_dv]), 32'hA5);
    chk("t1_stop_err", 32'(n_se - s_se), 32'd0);
    chk("t1_pe_count", 32'(n_pe - s_pe), 32'd1);
    chk("t1_par_err",  32'(last_perr),   32'h0);

    // 2: start glitch of 3 clocks at Prescale 8
    snap();
    Prescale = 6'd8;
    PAR_EN   = 1'b1;
    RX_IN    = 1'b0;
    idle(3);
    RX_IN = 1'b1;
    idle(40);
    chk("t2_dv_count", 32'(n_dv - s_dv), 32'd0);
    chk("t2_se_count", 32'(n_se - s_se), 32'd0);
    chk("t2_pe_count", 32'(n_pe - s_pe), 32'd0);

    // 3: Prescale 16, 0x3C with wrong parity; inputs changed mid-frame
    snap();
    send_frame(8'h3C, 16, 1'b1, 1'b1, 1'b1, -1, 8);
    idle(40);
    chk("t3_pe_count", 32'(n_pe - s_pe), 32'd1);
    chk("t3_par_err",  32'(last_perr),   32'h1);
    chk("t3_dv_count", 32'(n_dv - s_dv), 32'd0);
    chk("t3_se_count", 32'(n_se - s_se), 32'd0);

    // 4: Prescale 8, no parity, 0x81 with stop bit 0
    snap();
    send_frame(8'h81, 8, 1'b0, 1'b0, 1'b0, -1, 8);
    idle(16);
    chk("t4_se_count", 32'(n_se - s_se), 32'd1);
    chk("t4_dv_count", 32'(n_dv - s_dv), 32'd0);
    chk("t4_p_data",   32'(P_Data),      32'h81);

    // 5: Prescale 32, back-to-back 0x3C then 0xC3
    snap();
    send_frame(8'h3C, 32, 1'b0, 1'b0, 1'b1, -1, 32);
    send_frame(8'hC3, 32, 1'b0, 1'b0, 1'b1, -1, 32);
    idle(80);
    chk("t5_dv_count", 32'(n_dv - s_dv), 32'd2);
    chk("t5_data0",    32'(dv_data[s_dv]),     32'h3C);
    chk("t5_data1",    32'(dv_data[s_dv + 1]), 32'hC3);
    chk("t5_se_count", 32'(n_se - s_se), 32'd0);

    // 6a: one-clock glitch on the H sample of data bit 3 (clock 4*8+4+1)
    snap();
    send_frame(8'h00, 8, 1'b0, 1'b0, 1'b1, 37, 8);
    idle(16);
    chk("t6_glitch_dv",   32'(n_dv - s_dv),   32'd1);
    chk("t6_glitch_data", 32'(dv_data[s_dv]), 32'h00);

    // 6b: reset in the middle of DATA after three 1 bits
    snap();
    Prescale = 6'd8;
    PAR_EN   = 1'b0;
    RX_IN    = 1'b0;
    idle(8);
    RX_IN = 1'b1;
    idle(24);
    chk("t6_pre_rst_p_data", 32'(P_Data), 32'hE0);
    Rst = 1'b0;
    #2;
    chk("t6_rst_sampled_bit", 32'(Sampled_bit), 32'h0);
    chk("t6_rst_p_data",      32'(P_Data),      32'h0);
    chk("t6_rst_parity_en",   32'(Parity_en),   32'h0);
    chk("t6_rst_data_valid",  32'(Data_valid),  32'h0);
    chk("t6_rst_stop_err",    32'(Stop_err),    32'h0);
    idle(2);
    Rst = 1'b1;
    idle(100);
    chk("t6_abandon_dv", 32'(n_dv - s_dv), 32'd0);
    chk("t6_abandon_se", 32'(n_se - s_se), 32'd0);

    // 6c: clean frame after reset
    snap();
    send_frame(8'h55, 8, 1'b0, 1'b0, 1'b1, -1, 8);
    idle(16);
    chk("t6_post_dv",   32'(n_dv - s_dv),   32'd1);
    chk("t6_post_data", 32'(dv_data[s_dv]), 32'h55);
    chk("t6_post_se",   32'(n_se - s_se),   32'd0);

    chk("dv_se_exclusive", 32'(n_both), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
